// File: rtl/des_pkg.sv
// DES tables, permutation helpers, the round function f, key-rotation
// schedules and the engine state enum, shared by the des_decrypt_iter files.
package des_pkg;

    localparam int DES_BLOCK_W  = 64;
    localparam int DES_HALF_W   = 32;
    localparam int DES_KEY_W    = 64;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_CD_W     = 28;

    typedef enum logic [1:0] {IDLE, RUN, DONE} des_state_e;

    // All tables use DES numbering: position 1 is the MSB of the source word.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // S-boxes, row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Rotation applied to C/D before each round: right for decrypt, left for encrypt.
    localparam logic [0:15][1:0] DEC_ROT = {2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [0:15][1:0] ENC_ROT = {2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    // Parity bits (8,16,..,64) are simply never selected.
    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = x[47-6*i -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

endpackage

// File: rtl/des_key_sched_step.sv
// One key-schedule step: rotate C and D by 0..2, then PC2 to a 48-bit subkey.
// Rotation is right-only unless DES_DEC_ENC_MODE_EN adds the left (encrypt) path.
module des_key_sched_step
    import des_pkg::*;
(
    input  logic [DES_CD_W-1:0]     i_c,
    input  logic [DES_CD_W-1:0]     i_d,
    input  logic [1:0]              i_amt,
`ifdef DES_DEC_ENC_MODE_EN
    input  logic                    i_left,
`endif
    output logic [DES_CD_W-1:0]     o_c,
    output logic [DES_CD_W-1:0]     o_d,
    output logic [DES_SUBKEY_W-1:0] o_subkey
);

    function automatic logic [DES_CD_W-1:0] rot_r(input logic [DES_CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

`ifdef DES_DEC_ENC_MODE_EN
    function automatic logic [DES_CD_W-1:0] rot_l(input logic [DES_CD_W-1:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction
`endif

    // Rotate both halves; direction picked by mode when encrypt is built in
    always_comb begin
        o_c = rot_r(i_c, i_amt);
        o_d = rot_r(i_d, i_amt);
`ifdef DES_DEC_ENC_MODE_EN
        if (i_left) begin
            o_c = rot_l(i_c, i_amt);
            o_d = rot_l(i_d, i_amt);
        end
`endif
    end

    assign o_subkey = des_pc2({o_c, o_d});

endmodule

// File: rtl/round.sv
// Single DES Feistel round: L' = R, R' = L ^ f(R, K).
module round
    import des_pkg::*;
(
    input  logic [DES_HALF_W-1:0]   i_l,
    input  logic [DES_HALF_W-1:0]   i_r,
    input  logic [DES_SUBKEY_W-1:0] i_k,
    output logic [DES_HALF_W-1:0]   o_l,
    output logic [DES_HALF_W-1:0]   o_r
);

    assign o_l = i_r;
    assign o_r = i_l ^ des_f(i_r, i_k);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption engine, ROUNDS_PER_CYCLE rounds per clock.
// DES_DEC_ENC_MODE_EN adds a decrypt_i port selecting encrypt (0) or decrypt (1).
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DES_BLOCK_W-1:0] ct_i,
    input  logic [DES_KEY_W-1:0]   key_i,
`ifdef DES_DEC_ENC_MODE_EN
    input  logic                   decrypt_i,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DES_BLOCK_W-1:0] pt_o,
    output logic                   busy
);

    localparam int N     = 16 / ROUNDS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("des_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    des_state_e              r_state, w_state_nxt;
    logic [DES_HALF_W-1:0]   r_l, r_r;
    logic [DES_CD_W-1:0]     r_c, r_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [DES_BLOCK_W-1:0]  r_pt;
`ifdef DES_DEC_ENC_MODE_EN
    logic                    r_enc;
`endif
    logic                    w_accept, w_last;
    logic [DES_BLOCK_W-1:0]  w_ip;
    logic [55:0]             w_pc1;

    // Combinational round chain; element 0 is the register, last is next state
    logic [DES_HALF_W-1:0]   w_l [ROUNDS_PER_CYCLE+1];
    logic [DES_HALF_W-1:0]   w_r [ROUNDS_PER_CYCLE+1];
    logic [DES_CD_W-1:0]     w_c [ROUNDS_PER_CYCLE+1];
    logic [DES_CD_W-1:0]     w_d [ROUNDS_PER_CYCLE+1];

    assign w_ip     = des_ip(ct_i);
    assign w_pc1    = des_pc1(key_i);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_W'(N - 1));
    assign pt_o     = r_pt;

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_slice
        logic [3:0]              w_idx;
        logic [1:0]              w_amt;
        logic [DES_SUBKEY_W-1:0] w_k;

        // Absolute round number (0-based) of this slice within the 16
        assign w_idx = 4'(int'(r_cnt) * ROUNDS_PER_CYCLE + g);
`ifdef DES_DEC_ENC_MODE_EN
        assign w_amt = r_enc ? ENC_ROT[w_idx] : DEC_ROT[w_idx];
`else
        assign w_amt = DEC_ROT[w_idx];
`endif

        des_key_sched_step u_ks (
            .i_c      (w_c[g]),
            .i_d      (w_d[g]),
            .i_amt    (w_amt),
`ifdef DES_DEC_ENC_MODE_EN
            .i_left   (r_enc),
`endif
            .o_c      (w_c[g+1]),
            .o_d      (w_d[g+1]),
            .o_subkey (w_k)
        );

        round u_rnd (
            .i_l (w_l[g]),
            .i_r (w_r[g]),
            .i_k (w_k),
            .o_l (w_l[g+1]),
            .o_r (w_r[g+1])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; no accept while DONE, even if drained
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, advance the chain in RUN, capture result on last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l   <= '0;
            r_r   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_pt  <= '0;
`ifdef DES_DEC_ENC_MODE_EN
            r_enc <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_l   <= w_ip[63:32];
                    r_r   <= w_ip[31:0];
                    r_c   <= w_pc1[55:28];
                    r_d   <= w_pc1[27:0];
                    r_cnt <= '0;
`ifdef DES_DEC_ENC_MODE_EN
                    r_enc <= !decrypt_i;
`endif
                end
                RUN: begin
                    r_l   <= w_l[ROUNDS_PER_CYCLE];
                    r_r   <= w_r[ROUNDS_PER_CYCLE];
                    r_c   <= w_c[ROUNDS_PER_CYCLE];
                    r_d   <= w_d[ROUNDS_PER_CYCLE];
                    r_cnt <= r_cnt + 1'b1;
                    // Final swap: output is FP(R16 || L16)
                    if (w_last) r_pt <= des_fp({w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});
                end
                default: ;
            endcase
        end
    end

endmodule
